// File: rtl/dphy_rx_lane.sv
// D-PHY receive data lane: LP entry tracking, HS sync hunt at any bit offset, byte-aligned payload out.
// Latency: LP pins to FSM decision 2 cycles; sync found in cycle N -> sync_o N+1, first payload byte N+2.
// Backpressure: none; the lane emits one byte per word clock while in HS and cannot be stalled.
module dphy_rx_lane #(
    parameter int unsigned g_settle_cycles = 4,
    parameter int unsigned g_sync_timeout  = 32,
    parameter logic [7:0]  g_sync_byte     = 8'hB8
) (
    input  logic       clk_word_i,
    input  logic       rst_i,
    input  logic [7:0] serdes_d_i,
    input  logic       lp_p_i,
    input  logic       lp_n_i,
    output logic [1:0] lp_state_o,
    output logic       hs_active_o,
    output logic       sync_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       sot_err_o,
    output logic       eot_o
);

    typedef enum logic [2:0] {
        S_WAIT_STOP,
        S_STOP,
        S_HS_RQST,
        S_SETTLE,
        S_HUNT,
        S_RECEIVE
    } state_t;

    // Counters hold "cycles already spent", so the exit test compares against count-1.
    localparam logic [7:0] SETTLE_LAST  = 8'(g_settle_cycles - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(g_sync_timeout - 1);

    state_t      state_q;
    logic [1:0]  lp_meta_q;
    logic [1:0]  lp_sync_q;
    logic [7:0]  w_prev_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic [2:0]  off_q;
    logic        hs_q;
    logic        sync_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        sot_q;
    logic        eot_q;
    logic [15:0] window;
    logic        match;
    logic [2:0]  match_off;

    // Two-word view of the bit stream; w_prev bit 0 is the oldest bit.
    assign window  = {serdes_d_i, w_prev_q};
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Search all eight bit offsets; scanning downwards lets the lowest matching offset win.
    always_comb begin
        match     = 1'b0;
        match_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (window[k +: 8] == g_sync_byte) begin
                match     = 1'b1;
                match_off = 3'(k);
            end
        end
    end

    // LP pin synchronizers (preset to stop state) and previous-word register.
    always_ff @(posedge clk_word_i) begin
        w_prev_q <= serdes_d_i;
        if (rst_i) begin
            lp_meta_q <= 2'b11;
            lp_sync_q <= 2'b11;
        end else begin
            lp_meta_q <= {lp_p_i, lp_n_i};
            lp_sync_q <= lp_meta_q;
        end
    end

    // Lane FSM with all outputs registered; pulse outputs default low every cycle.
    always_ff @(posedge clk_word_i) begin
        if (rst_i) begin
            state_q <= S_WAIT_STOP;
            cnt_q   <= 8'd0;
            off_q   <= 3'd0;
            hs_q    <= 1'b0;
            sync_q  <= 1'b0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            sot_q   <= 1'b0;
            eot_q   <= 1'b0;
        end else begin
            sync_q <= 1'b0;
            sot_q  <= 1'b0;
            eot_q  <= 1'b0;
            case (state_q)
                S_WAIT_STOP: begin
                    if (lp_sync_q == 2'b11) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (lp_sync_q == 2'b01)      state_q <= S_HS_RQST;
                    else if (lp_sync_q != 2'b11) state_q <= S_WAIT_STOP;
                end
                S_HS_RQST: begin
                    case (lp_sync_q)
                        2'b00: begin
                            state_q <= S_SETTLE;
                            cnt_q   <= 8'd0;
                        end
                        2'b01:   state_q <= S_HS_RQST;
                        2'b11:   state_q <= S_STOP;
                        default: state_q <= S_WAIT_STOP;
                    endcase
                end
                S_SETTLE: begin
                    // Words seen here are settle noise; any sync-like pattern is ignored.
                    if (lp_sync_q != 2'b00) begin
                        sot_q   <= 1'b1;
                        state_q <= S_WAIT_STOP;
                    end else if (cnt_q >= SETTLE_LAST) begin
                        state_q <= S_HUNT;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_HUNT: begin
                    // An LP change beats a match; a match beats the timeout.
                    if (lp_sync_q != 2'b00) begin
                        sot_q   <= 1'b1;
                        state_q <= S_WAIT_STOP;
                    end else if (match) begin
                        off_q   <= match_off;
                        sync_q  <= 1'b1;
                        hs_q    <= 1'b1;
                        state_q <= S_RECEIVE;
                    end else if (cnt_q >= TIMEOUT_LAST) begin
                        sot_q   <= 1'b1;
                        state_q <= S_WAIT_STOP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_RECEIVE: begin
                    // Trailer and settle garbage pass through until LP leaves 00.
                    if (lp_sync_q == 2'b00) begin
                        data_q  <= window[off_q +: 8];
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                        hs_q    <= 1'b0;
                        if (lp_sync_q == 2'b11) begin
                            eot_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            state_q <= S_WAIT_STOP;
                        end
                    end
                end
                default: state_q <= S_WAIT_STOP;
            endcase
        end
    end

    assign lp_state_o  = lp_sync_q;
    assign hs_active_o = hs_q;
    assign sync_o      = sync_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign sot_err_o   = sot_q;
    assign eot_o       = eot_q;

endmodule

// File: tb/tb_dphy_rx_lane.sv
// Directed bench for dphy_rx_lane: bursts at every bit offset, timeout, aborted entries, reset mid-burst.
// Latency: inputs are applied per word clock; outputs are sampled 1 time unit after the capturing edge.
// Backpressure: not applicable; the lane stream has no ready signal.
module tb_dphy_rx_lane;

    logic       clk;
    logic       rst;
    logic [7:0] serdes_d;
    logic       lp_p;
    logic       lp_n;
    logic [1:0] lp_state_o;
    logic       hs_active_o;
    logic       sync_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       sot_err_o;
    logic       eot_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int n_sync = 0;
    int n_valid = 0;
    int n_eot = 0;
    int n_sot = 0;

    dphy_rx_lane #(
        .g_settle_cycles(4),
        .g_sync_timeout (32),
        .g_sync_byte    (8'hB8)
    ) dut (
        .clk_word_i (clk),
        .rst_i      (rst),
        .serdes_d_i (serdes_d),
        .lp_p_i     (lp_p),
        .lp_n_i     (lp_n),
        .lp_state_o (lp_state_o),
        .hs_active_o(hs_active_o),
        .sync_o     (sync_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .sot_err_o  (sot_err_o),
        .eot_o      (eot_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one word clock of inputs, then sample just after the edge and tally pulses.
    task automatic tick(input logic [7:0] d, input logic [1:0] lp, input logic r);
        serdes_d = d;
        lp_p     = lp[1];
        lp_n     = lp[0];
        rst      = r;
        @(posedge clk);
        #1;
        if (sync_o === 1'b1)    n_sync++;
        if (valid_o === 1'b1)   n_valid++;
        if (eot_o === 1'b1)     n_eot++;
        if (sot_err_o === 1'b1) n_sot++;
    endtask

    task automatic clear_counts();
        n_sync = 0; n_valid = 0; n_eot = 0; n_sot = 0;
    endtask

    // Stream: 8 zero words, then B8 11 22 33 starting at bit offset s; optional decoy B8 in word 2.
    function automatic logic [7:0] word(input int s, input int j, input bit fs);
        logic [127:0] v;
        v = 128'h33_22_11_B8;
        v = v << (64 + s);
        if (fs) v[23:16] = 8'hB8;
        return v[8*j +: 8];
    endfunction

    // Idle in LP-11, then three cycles of LP-01 (HS request).
    task automatic enter();
        for (int i = 0; i < 4; i++) tick(8'h00, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) tick(8'h00, 2'b01, 1'b0);
    endtask

    task automatic run_burst(input int s, input bit fs);
        logic [7:0] pay [0:2];
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        enter();
        clear_counts();
        for (int j = 0; j < 13; j++) begin
            tick(word(s, j, fs), (j < 11) ? 2'b00 : 2'b11, 1'b0);
            if (j == 8) check($sformatf("s%0d sync_early", s), sync_o, 1'b0);
            if (j == 9) begin
                check($sformatf("s%0d sync", s), sync_o, 1'b1);
                check($sformatf("s%0d hs_on", s), hs_active_o, 1'b1);
                check($sformatf("s%0d valid_pre", s), valid_o, 1'b0);
            end
            if (j >= 10) begin
                check($sformatf("s%0d valid%0d", s, j - 10), valid_o, 1'b1);
                check($sformatf("s%0d data%0d", s, j - 10), data_o, pay[j-10]);
            end
        end
        tick(8'h00, 2'b11, 1'b0);
        check($sformatf("s%0d eot", s), eot_o, 1'b1);
        check($sformatf("s%0d valid_end", s), valid_o, 1'b0);
        check($sformatf("s%0d hs_off", s), hs_active_o, 1'b0);
        tick(8'h00, 2'b11, 1'b0);
        check($sformatf("s%0d eot_once", s), eot_o, 1'b0);
        check($sformatf("s%0d n_sync", s), n_sync, 1);
        check($sformatf("s%0d n_valid", s), n_valid, 3);
        check($sformatf("s%0d n_eot", s), n_eot, 1);
        check($sformatf("s%0d n_sot", s), n_sot, 0);
    endtask

    initial begin
        // Reset with LP pins low: synchronizer preset must still show stop state.
        tick(8'h00, 2'b00, 1'b1);
        tick(8'h00, 2'b00, 1'b1);
        check("rst lp_state", lp_state_o, 2'b11);
        check("rst hs_active", hs_active_o, 1'b0);
        check("rst sync", sync_o, 1'b0);
        check("rst data", data_o, 8'h00);
        check("rst valid", valid_o, 1'b0);
        check("rst sot_err", sot_err_o, 1'b0);
        check("rst eot", eot_o, 1'b0);
        for (int i = 0; i < 3; i++) tick(8'h00, 2'b11, 1'b0);

        // Aligned and every shifted offset.
        for (int s = 0; s < 8; s++) run_burst(s, 1'b0);

        // Decoy sync during settle; real sync at offset 5 must be the one used.
        run_burst(5, 1'b1);

        // Sync timeout: 32 hunted words of zeros.
        enter();
        clear_counts();
        for (int i = 0; i < 46; i++) begin
            tick(8'h00, 2'b00, 1'b0);
            if (i == 37) check("tmo before", sot_err_o, 1'b0);
            if (i == 38) check("tmo pulse", sot_err_o, 1'b1);
            if (i == 39) check("tmo after", sot_err_o, 1'b0);
        end
        check("tmo n_sot", n_sot, 1);
        check("tmo n_sync", n_sync, 0);
        check("tmo n_valid", n_valid, 0);
        run_burst(2, 1'b0);

        // Aborted entry 11->01->11: no error.
        enter();
        clear_counts();
        for (int i = 0; i < 4; i++) tick(8'h00, 2'b11, 1'b0);
        check("abortA n_sot", n_sot, 0);
        check("abortA n_sync", n_sync, 0);

        // Aborted entry 11->01->00->11 inside settle: one error pulse.
        enter();
        clear_counts();
        tick(8'h00, 2'b00, 1'b0);
        tick(8'h00, 2'b00, 1'b0);
        for (int i = 2; i < 8; i++) begin
            tick(8'h00, 2'b11, 1'b0);
            if (i == 3) check("abortB before", sot_err_o, 1'b0);
            if (i == 4) check("abortB pulse", sot_err_o, 1'b1);
            if (i == 5) check("abortB after", sot_err_o, 1'b0);
        end
        check("abortB n_sot", n_sot, 1);
        run_burst(4, 1'b0);

        // Reset asserted while the 2nd payload byte is on data_o.
        enter();
        clear_counts();
        for (int j = 0; j < 11; j++) tick(word(0, j, 1'b0), 2'b00, 1'b0);
        check("rstmid data0", data_o, 8'h11);
        tick(word(0, 11, 1'b0), 2'b00, 1'b0);
        check("rstmid data1", data_o, 8'h22);
        tick(word(0, 12, 1'b0), 2'b00, 1'b1);
        check("rstmid valid", valid_o, 1'b0);
        check("rstmid lp_state", lp_state_o, 2'b11);
        check("rstmid hs_active", hs_active_o, 1'b0);
        check("rstmid eot", eot_o, 1'b0);
        tick(8'h00, 2'b00, 1'b0);
        tick(8'h00, 2'b00, 1'b0);
        check("rstmid n_eot", n_eot, 0);
        check("rstmid valid_after", valid_o, 1'b0);
        run_burst(7, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
